// File: rtl/cpri_pus_lane_deskew_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpri_pus_lane_deskew_pkg
//  Brief    : Shared lane count and FSM encoding for the PUSCH lane deskew.
//  Revision : 1.0  initial release
// ============================================================================
package cpri_pus_lane_deskew_pkg;

    localparam int NUM_LANE = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKEW  = 2'd1,
        ST_OUT   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpri_pus_lane_deskew_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpri_pus_lane_deskew_if
//  Brief    : Four-lane PUSCH input bus and aligned output/status bus.
//  Revision : 1.0  initial release
// ============================================================================
interface cpri_pus_lane_deskew_if #(
    parameter int DAT_DW = 64
) ();
    localparam int NL = cpri_pus_lane_deskew_pkg::NUM_LANE;

    logic [NL-1:0]        pus_sop_i;
    logic [NL*DAT_DW-1:0] pus_dat_i;
    logic                 pus_sop_o;
    logic                 pus_vld_o;
    logic [NL*DAT_DW-1:0] pus_dat_o;
    logic [7:0]           skew_o;
    logic                 skew_err_o;
    logic [NL-1:0]        err_lane_o;
    logic                 sop_err_o;

    modport master (
        output pus_sop_i, pus_dat_i,
        input  pus_sop_o, pus_vld_o, pus_dat_o, skew_o, skew_err_o, err_lane_o, sop_err_o
    );

    modport slave (
        input  pus_sop_i, pus_dat_i,
        output pus_sop_o, pus_vld_o, pus_dat_o, skew_o, skew_err_o, err_lane_o, sop_err_o
    );
endinterface
`default_nettype wire

// File: rtl/cpri_pus_lane_deskew_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pus_lane_fifo
//  Brief    : Per-lane packet capture, sync FIFO with registered read, pkt count.
//  Revision : 1.0  initial release
// ============================================================================
module pus_lane_fifo #(
    parameter int DAT_DW   = 64,
    parameter int FRM_LEN  = 96,
    parameter int FF_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sop,
    input  logic [DAT_DW-1:0] dat,
    input  logic              pop,
    input  logic              dec,
    output logic [DAT_DW-1:0] rd_dat,
    output logic              empty,
    output logic [1:0]        pkt_cnt,
    output logic              sop_err
);
    localparam int AW = $clog2(FF_DEPTH);
    localparam int WW = $clog2(FRM_LEN);
    localparam logic [WW-1:0] W_LAST = WW'(FRM_LEN - 1);

    logic [DAT_DW-1:0] mem [FF_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WW-1:0]     wcnt;
    logic              cap;
    logic              full;
    logic              sop_ok;
    logic              wr_req;
    logic              wr_en;
    logic              rd_en;

    always_comb begin
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty   = (wr_ptr == rd_ptr);
        sop_ok  = sop && !cap && (pkt_cnt != 2'd3);
        wr_req  = sop_ok || cap;
        wr_en   = wr_req && !full;
        rd_en   = pop && !empty;
        sop_err = (sop && !sop_ok) || (wr_req && full);
    end

    // wcnt holds the index of the next word to be written while cap is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap     <= 1'b0;
            wcnt    <= '0;
            pkt_cnt <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_dat  <= '0;
        end else begin
            if (sop_ok) begin
                cap  <= (FRM_LEN > 1);
                wcnt <= WW'(1);
            end else if (cap) begin
                if (wcnt == W_LAST) begin
                    cap  <= 1'b0;
                    wcnt <= '0;
                end else begin
                    wcnt <= wcnt + WW'(1);
                end
            end
            pkt_cnt <= pkt_cnt + 2'(sop_ok) - 2'(dec);
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                rd_dat <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= dat;
    end

endmodule
`default_nettype wire

// File: rtl/cpri_pus_lane_deskew.sv
`default_nettype none
// ============================================================================
//  Module   : cpri_pus_lane_deskew
//  Brief    : Buffers four PUSCH lanes and replays them in lockstep; flushes late lanes.
//  Revision : 1.0  initial release
// ============================================================================
module cpri_pus_lane_deskew
    import cpri_pus_lane_deskew_pkg::*;
#(
    parameter int DAT_DW   = 64,
    parameter int FRM_LEN  = 96,
    parameter int FF_DEPTH = 256,
    parameter int MAX_SKEW = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cpri_pus_lane_deskew_if.slave  bus
);
    localparam int RW = $clog2(FRM_LEN);
    localparam int FW = $clog2(FRM_LEN + 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(FRM_LEN - 1);
    localparam logic [FW-1:0] FL_LEN    = FW'(FRM_LEN);
    localparam logic [7:0]    SKEW_LAST = 8'(MAX_SKEW - 1);

    state_t                      state;
    state_t                      next_state;
    logic [7:0]                  skew_cnt;
    logic [RW-1:0]               rd_cnt;
    logic [FW-1:0]               flush_cnt [NUM_LANE];
    logic [DAT_DW-1:0]           lane_dat  [NUM_LANE];
    logic [1:0]                  pkt_cnt   [NUM_LANE];
    logic                        lane_empty[NUM_LANE];
    logic                        lane_err  [NUM_LANE];
    logic [NUM_LANE-1:0]         nz;
    logic [NUM_LANE-1:0]         empty_v;
    logic [NUM_LANE-1:0]         fl_done;
    logic [NUM_LANE-1:0]         pop;
    logic [NUM_LANE-1:0]         dec;
    logic [NUM_LANE*DAT_DW-1:0]  rd_cat;
    logic                        any_err;
    logic                        to_flush;
    logic                        rd_vld;
    logic                        rd_sop;

    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        pus_lane_fifo #(
            .DAT_DW   (DAT_DW),
            .FRM_LEN  (FRM_LEN),
            .FF_DEPTH (FF_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .sop     (bus.pus_sop_i[k]),
            .dat     (bus.pus_dat_i[k*DAT_DW +: DAT_DW]),
            .pop     (pop[k]),
            .dec     (dec[k]),
            .rd_dat  (lane_dat[k]),
            .empty   (lane_empty[k]),
            .pkt_cnt (pkt_cnt[k]),
            .sop_err (lane_err[k])
        );
    end

    always_comb begin
        nz      = '0;
        empty_v = '0;
        fl_done = '0;
        rd_cat  = '0;
        any_err = 1'b0;
        for (int k = 0; k < NUM_LANE; k++) begin
            nz[k]      = (pkt_cnt[k] != 2'd0);
            empty_v[k] = lane_empty[k];
            fl_done[k] = !bus.err_lane_o[k] || (flush_cnt[k] == FL_LEN);
            rd_cat[k*DAT_DW +: DAT_DW] = lane_dat[k];
            any_err    = any_err | lane_err[k];
        end
    end

    always_comb begin
        next_state = state;
        pop        = '0;
        dec        = '0;
        to_flush   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (&nz)      next_state = ST_OUT;
                else if (|nz) next_state = ST_SKEW;
            end
            ST_SKEW: begin
                if (&nz) begin
                    next_state = ST_OUT;
                end else if (skew_cnt == SKEW_LAST) begin
                    next_state = ST_FLUSH;
                    to_flush   = 1'b1;
                end
            end
            ST_OUT: begin
                pop = '1;
                // pkt_cnt already reflects the packet being read out
                if (rd_cnt == RD_LAST) next_state = (&nz) ? ST_OUT : ST_IDLE;
            end
            ST_FLUSH: begin
                pop = ~fl_done & ~empty_v;
                if (&fl_done) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (next_state == ST_OUT && (state != ST_OUT || rd_cnt == RD_LAST)) dec = '1;
        else if (to_flush)                                                   dec = nz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            skew_cnt       <= 8'd0;
            rd_cnt         <= '0;
            for (int k = 0; k < NUM_LANE; k++) flush_cnt[k] <= '0;
            rd_vld         <= 1'b0;
            rd_sop         <= 1'b0;
            bus.pus_sop_o  <= 1'b0;
            bus.pus_vld_o  <= 1'b0;
            bus.pus_dat_o  <= '0;
            bus.skew_o     <= 8'd0;
            bus.skew_err_o <= 1'b0;
            bus.err_lane_o <= '0;
            bus.sop_err_o  <= 1'b0;
        end else begin
            state    <= next_state;
            skew_cnt <= (state == ST_SKEW) ? skew_cnt + 8'd1 : 8'd0;
            rd_cnt   <= (state == ST_OUT && rd_cnt != RD_LAST) ? rd_cnt + RW'(1) : '0;
            for (int k = 0; k < NUM_LANE; k++)
                flush_cnt[k] <= (state == ST_FLUSH) ? flush_cnt[k] + FW'(pop[k]) : '0;

            if (state == ST_IDLE && next_state == ST_OUT)      bus.skew_o <= 8'd0;
            else if (state == ST_SKEW && next_state == ST_OUT) bus.skew_o <= skew_cnt + 8'd1;

            bus.skew_err_o <= to_flush;
            if (to_flush) bus.err_lane_o <= nz;

            // FIFO read register, then output register
            rd_vld        <= (state == ST_OUT);
            rd_sop        <= (state == ST_OUT) && (rd_cnt == '0);
            bus.pus_vld_o <= rd_vld;
            bus.pus_sop_o <= rd_sop;
            bus.pus_dat_o <= rd_vld ? rd_cat : '0;
            bus.sop_err_o <= any_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpri_pus_lane_deskew.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpri_pus_lane_deskew
//  Brief    : Directed self-checking bench for the four-lane PUSCH deskew.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpri_pus_lane_deskew;
    localparam int DAT_DW   = 64;
    localparam int FRM_LEN  = 96;
    localparam int FF_DEPTH = 256;
    localparam int MAX_SKEW = 64;

    typedef struct {
        int cyc;
        int lane;
        int pkt;
    } ev_t;

    typedef struct packed {
        logic [31:0]     cyc;
        logic [7:0]      skew;
        logic [3:0][7:0] pkt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpri_pus_lane_deskew_if #(.DAT_DW(DAT_DW)) bus ();

    cpri_pus_lane_deskew #(
        .DAT_DW   (DAT_DW),
        .FRM_LEN  (FRM_LEN),
        .FF_DEPTH (FF_DEPTH),
        .MAX_SKEW (MAX_SKEW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    ev_t  evq[$];
    exp_t expq[$];
    exp_t cur;
    bit   act [4];
    int   wc  [4];
    int   pk  [4];
    bit   out_act = 1'b0;
    int   ow = 0;
    int   sop_err_n = 0;
    int   skew_err_n = 0;
    int   skew_err_cyc = -1;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int lane, input int pkt, input int w);
        return {8'hA5, lane[7:0], pkt[7:0], 8'h00, w[31:0]};
    endfunction

    task automatic add_ev(input int c, input int lane, input int pkt);
        ev_t e;
        e.cyc = c; e.lane = lane; e.pkt = pkt;
        evq.push_back(e);
    endtask

    task automatic add_set(input int c, input int pkt);
        for (int k = 0; k < 4; k++) add_ev(c, k, pkt);
    endtask

    task automatic push_exp(input int c, input int skew, input int pkt);
        exp_t e;
        e.cyc  = 32'(c);
        e.skew = 8'(skew);
        for (int k = 0; k < 4; k++) e.pkt[k] = 8'(pkt);
        expq.push_back(e);
    endtask

    task automatic monitor();
        logic [255:0] e;
        if (out_act && ow == FRM_LEN) out_act = 1'b0;
        if (bus.pus_sop_o) begin
            check_eq("sop_cyc", 256'(cyc), (expq.size() != 0) ? 256'(expq[0].cyc) : '1);
            if (expq.size() != 0) begin
                cur = expq.pop_front();
                check_eq("skew", 256'(bus.skew_o), 256'(cur.skew));
                out_act = 1'b1;
                ow = 0;
            end
        end
        check_eq("vld", 256'(bus.pus_vld_o), 256'(out_act));
        if (out_act) begin
            for (int k = 0; k < 4; k++) e[k*DAT_DW +: DAT_DW] = pat(k, int'(cur.pkt[k]), ow);
            check_eq("dat", bus.pus_dat_o, e);
            ow++;
        end
        if (bus.skew_err_o) begin
            skew_err_n++;
            skew_err_cyc = cyc;
        end
        if (bus.sop_err_o) sop_err_n++;
    endtask

    task automatic step();
        logic [3:0]   sop;
        logic [255:0] dat;
        int           k;
        sop = '0;
        dat = '0;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].cyc == cyc) begin
                k = evq[i].lane;
                sop[k] = 1'b1;
                if (evq[i].pkt >= 0) begin
                    act[k] = 1'b1;
                    wc[k]  = 0;
                    pk[k]  = evq[i].pkt;
                end
            end
        end
        for (int j = 0; j < 4; j++)
            if (act[j]) dat[j*DAT_DW +: DAT_DW] = pat(j, pk[j], wc[j]);
        bus.pus_sop_i = sop;
        bus.pus_dat_i = dat;
        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < 4; j++) begin
            if (act[j]) begin
                wc[j]++;
                if (wc[j] == FRM_LEN) act[j] = 1'b0;
            end
        end
        monitor();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic new_test();
        cyc = 0;
        evq.delete();
        sop_err_n = 0;
        skew_err_n = 0;
        skew_err_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pus_sop_i = '0;
        bus.pus_dat_i = '0;
        for (int k = 0; k < 4; k++) act[k] = 1'b0;
        evq.delete();
        expq.delete();
        out_act = 1'b0;
        ow = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        bus.pus_sop_i = '0;
        bus.pus_dat_i = '0;
        for (int k = 0; k < 4; k++) begin
            act[k] = 1'b0; wc[k] = 0; pk[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_sop",      256'(bus.pus_sop_o),  256'(0));
        check_eq("rst_vld",      256'(bus.pus_vld_o),  256'(0));
        check_eq("rst_dat",      bus.pus_dat_o,        256'(0));
        check_eq("rst_skew",     256'(bus.skew_o),     256'(0));
        check_eq("rst_skew_err", 256'(bus.skew_err_o), 256'(0));
        check_eq("rst_err_lane", 256'(bus.err_lane_o), 256'(0));
        check_eq("rst_sop_err",  256'(bus.sop_err_o),  256'(0));
        do_reset();

        // all four lanes aligned
        new_test();
        add_set(100, 1);
        push_exp(104, 0, 1);
        run_until(250);
        check_eq("t1_pending", 256'(expq.size()), 256'(0));
        check_eq("t1_sop_err", 256'(sop_err_n), 256'(0));

        // lane 2 five cycles late
        new_test();
        add_ev(100, 0, 2); add_ev(100, 1, 2); add_ev(100, 3, 2); add_ev(105, 2, 2);
        push_exp(109, 5, 2);
        run_until(250);
        check_eq("t2_pending", 256'(expq.size()), 256'(0));

        // lane 3 missing: timeout and flush, then a clean set
        new_test();
        add_ev(100, 0, 3); add_ev(100, 1, 3); add_ev(100, 2, 3);
        run_until(300);
        check_eq("t3_skew_err_n",   256'(skew_err_n),     256'(1));
        check_eq("t3_skew_err_cyc", 256'(skew_err_cyc),   256'(166));
        check_eq("t3_err_lane",     256'(bus.err_lane_o), 256'(4'b0111));
        add_set(400, 4);
        push_exp(404, 0, 4);
        run_until(560);
        check_eq("t3_pending",    256'(expq.size()),    256'(0));
        check_eq("t3_err_held",   256'(bus.err_lane_o), 256'(4'b0111));
        check_eq("t3_no_new_err", 256'(skew_err_n),     256'(1));

        // back-to-back packets with lane k delayed by k cycles
        new_test();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) add_ev(100 + k + 96*p, k, 10 + p);
            push_exp(107 + 96*p, 3, 10 + p);
        end
        run_until(520);
        check_eq("t4_pending", 256'(expq.size()), 256'(0));
        check_eq("t4_sop_err", 256'(sop_err_n),   256'(0));

        // stray sop on lane 1 at word 40
        new_test();
        add_set(100, 20);
        add_ev(140, 1, -1);
        push_exp(104, 0, 20);
        run_until(250);
        check_eq("t5_pending", 256'(expq.size()), 256'(0));
        check_eq("t5_sop_err", 256'(sop_err_n),   256'(1));

        // reset in the middle of replay
        new_test();
        add_set(100, 30);
        push_exp(104, 0, 30);
        run_until(152);
        check_eq("t6_mid_vld", 256'(bus.pus_vld_o), 256'(1));
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_vld",  256'(bus.pus_vld_o), 256'(0));
        check_eq("t6_rst_dat",  bus.pus_dat_o,       256'(0));
        check_eq("t6_rst_sop",  256'(bus.pus_sop_o), 256'(0));
        do_reset();
        new_test();
        add_set(100, 31);
        push_exp(104, 0, 31);
        run_until(250);
        check_eq("t6_pending", 256'(expq.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
